// File: rtl/path_player_if.sv
// Handshake bundle between the path replayer, its path queue and the display sink.
interface path_player_if #(
    parameter int unsigned COORD_W = 4
);
    logic               read_start;
    logic               q_empty;
    logic [1:0]         q_data;
    logic               q_deq;
    logic               move_valid;
    logic               move_ready;
    logic [1:0]         move_dir;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [7:0]         step_cnt;
    logic               read_path_finished;

    modport master (
        input  read_start, q_empty, q_data, move_ready,
        output q_deq, move_valid, move_dir, pos_x, pos_y, step_cnt, read_path_finished
    );

    modport slave (
        output read_start, q_empty, q_data, move_ready,
        input  q_deq, move_valid, move_dir, pos_x, pos_y, step_cnt, read_path_finished
    );
endinterface

// File: rtl/path_player.sv
// Replays a solved maze path from a direction queue, presenting each move
// with its resulting position to a display sink and pacing moves by a hold time.
module path_player #(
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    path_player_if.master bus
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        PRESENT = 3'd3,
        HOLD    = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic [1:0]         move_dir;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [7:0]         step_cnt;
    logic [7:0]         hold_cnt;
    logic               q_deq;
    logic               move_valid;
    logic               finished;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.read_start && armed) state_next = FETCH;
            FETCH:   state_next = bus.q_empty ? FINISH : LOAD;
            LOAD:    state_next = PRESENT;
            PRESENT: if (bus.move_ready) state_next = HOLD;
            HOLD:    if (hold_cnt == 8'd0) state_next = FETCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decoded from the current state; q_deq is gated by the live empty flag
    always_comb begin
        q_deq      = 1'b0;
        move_valid = 1'b0;
        finished   = 1'b0;
        case (state)
            FETCH:   q_deq      = ~bus.q_empty;
            PRESENT: move_valid = 1'b1;
            FINISH:  finished   = 1'b1;
            default: ;
        endcase
    end

    // Move data, position, step count and hold timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            move_dir <= 2'b00;
            pos_x    <= '0;
            pos_y    <= '0;
            step_cnt <= 8'd0;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A start level must be seen low before it can trigger a new replay
                    if (!bus.read_start) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed    <= 1'b0;
                        pos_x    <= '0;
                        pos_y    <= '0;
                        step_cnt <= 8'd0;
                    end
                end
                LOAD: begin
                    move_dir <= bus.q_data;
                    case (bus.q_data)
                        2'b00:   pos_y <= pos_y - COORD_W'(1);
                        2'b01:   pos_x <= pos_x + COORD_W'(1);
                        2'b10:   pos_x <= pos_x - COORD_W'(1);
                        default: pos_y <= pos_y + COORD_W'(1);
                    endcase
                end
                PRESENT: begin
                    if (bus.move_ready) begin
                        if (step_cnt != 8'hFF) step_cnt <= step_cnt + 8'd1;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.q_deq              = q_deq;
    assign bus.move_valid         = move_valid;
    assign bus.move_dir           = move_dir;
    assign bus.pos_x              = pos_x;
    assign bus.pos_y              = pos_y;
    assign bus.step_cnt           = step_cnt;
    assign bus.read_path_finished = finished;

endmodule

// File: tb/tb_path_player.sv
// Directed bench for path_player: table of path replays plus hand sequences
// for stall, restart gating, empty queue and mid-replay reset.
module tb_path_player;

    localparam int unsigned CW = 4;
    localparam int unsigned HC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    path_player_if #(.COORD_W(CW)) bus ();

    path_player #(.COORD_W(CW), .HOLD_CYCLES(HC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Path queue model: head data appears the cycle after a dequeue
    logic [1:0] qmem [64];
    int qhead = 0;
    int qend  = 0;
    assign bus.q_empty = (qhead >= qend);
    always @(posedge clk) begin
        if (bus.q_deq) begin
            bus.q_data <= qmem[qhead];
            qhead      <= qhead + 1;
        end
    end

    typedef struct packed {
        logic [2:0]           len;
        logic [3:0][1:0]      dir;
        logic [3:0][CW-1:0]   ex;
        logic [3:0][CW-1:0]   ey;
    } vec_t;

    vec_t vecs [5];
    int   checks   = 0;
    int   failures = 0;
    logic prev_deq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample_invariants();
        chk("deq_while_empty", 32'(bus.q_deq & bus.q_empty), 32'd0);
        chk("deq_back_to_back", 32'(bus.q_deq & prev_deq), 32'd0);
        prev_deq = bus.q_deq;
    endtask

    task automatic load_queue(input int n, input logic [3:0][1:0] d);
        for (int i = 0; i < n; i++) qmem[qhead + i] = d[i];
        qend = qhead + n;
    endtask

    task automatic arm_and_start();
        bus.read_start = 1'b0;
        tick();
        tick();
        bus.read_start = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q_deq"},      32'(bus.q_deq), 32'd0);
        chk({tag, "_move_valid"}, 32'(bus.move_valid), 32'd0);
        chk({tag, "_move_dir"},   32'(bus.move_dir), 32'd0);
        chk({tag, "_pos_x"},      32'(bus.pos_x), 32'd0);
        chk({tag, "_pos_y"},      32'(bus.pos_y), 32'd0);
        chk({tag, "_step_cnt"},   32'(bus.step_cnt), 32'd0);
        chk({tag, "_finished"},   32'(bus.read_path_finished), 32'd0);
    endtask

    task automatic wait_finish(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (bus.read_path_finished) seen = 1'b1;
        end
        chk({tag, "_finish_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nmov = 0, ndeq = 0, last_acc = -1;
        bit done = 1'b0;
        load_queue(int'(v.len), v.dir);
        bus.move_ready = 1'b1;
        arm_and_start();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            tick();
            sample_invariants();
            if (bus.q_deq) begin
                ndeq++;
                if (last_acc >= 0) chk($sformatf("v%0d_hold_gap", idx), 32'(cyc - last_acc), 32'(HC + 1));
            end
            if (bus.move_valid) begin
                if (nmov < 4) begin
                    chk($sformatf("v%0d_m%0d_dir", idx, nmov), 32'(bus.move_dir), 32'(v.dir[nmov]));
                    chk($sformatf("v%0d_m%0d_x", idx, nmov), 32'(bus.pos_x), 32'(v.ex[nmov]));
                    chk($sformatf("v%0d_m%0d_y", idx, nmov), 32'(bus.pos_y), 32'(v.ey[nmov]));
                end
                last_acc = cyc;
                nmov++;
            end
            if (bus.read_path_finished) done = 1'b1;
        end
        chk($sformatf("v%0d_finish_seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_moves", idx), 32'(nmov), 32'(v.len));
        chk($sformatf("v%0d_deqs", idx), 32'(ndeq), 32'(v.len));
        tick();
        chk($sformatf("v%0d_step_cnt", idx), 32'(bus.step_cnt), 32'(v.len));
        chk($sformatf("v%0d_single_pulse", idx), 32'(bus.read_path_finished), 32'd0);
        bus.read_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;

        vecs[0].len = 3'd3; vecs[0].dir = {2'b00, 2'b11, 2'b01, 2'b01};
        vecs[0].ex  = {4'd0, 4'd2, 4'd2, 4'd1}; vecs[0].ey = {4'd0, 4'd1, 4'd0, 4'd0};
        vecs[1].len = 3'd1; vecs[1].dir = {6'b0, 2'b10};
        vecs[1].ex  = {12'd0, 4'd15}; vecs[1].ey = 16'd0;
        vecs[2].len = 3'd1; vecs[2].dir = {6'b0, 2'b00};
        vecs[2].ex  = 16'd0; vecs[2].ey = {12'd0, 4'd15};
        vecs[3].len = 3'd4; vecs[3].dir = {2'b10, 2'b00, 2'b01, 2'b11};
        vecs[3].ex  = {4'd0, 4'd1, 4'd1, 4'd0}; vecs[3].ey = {4'd0, 4'd0, 4'd1, 4'd1};
        vecs[4].len = 3'd0; vecs[4].dir = 8'd0; vecs[4].ex = 16'd0; vecs[4].ey = 16'd0;

        rst = 1'b1;
        bus.read_start = 1'b0;
        bus.move_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Empty queue: finish pulse two cycles after start, nothing dequeued
        qend = qhead;
        arm_and_start();
        tick();
        chk("empty_fetch_deq", 32'(bus.q_deq), 32'd0);
        chk("empty_fetch_fin", 32'(bus.read_path_finished), 32'd0);
        tick();
        chk("empty_fin_pulse", 32'(bus.read_path_finished), 32'd1);
        chk("empty_no_valid", 32'(bus.move_valid), 32'd0);
        tick();
        chk("empty_fin_end", 32'(bus.read_path_finished), 32'd0);
        bus.read_start = 1'b0;

        // Sink stall: presented move held stable while ready is low
        load_queue(1, {6'b0, 2'b01});
        bus.move_ready = 1'b0;
        arm_and_start();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (bus.move_valid) seen = 1'b1;
        end
        chk("stall_present_reached", 32'(seen), 32'd1);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 32'(bus.move_valid), 32'd1);
            chk("stall_dir", 32'(bus.move_dir), 32'd1);
            chk("stall_x", 32'(bus.pos_x), 32'd1);
            chk("stall_y", 32'(bus.pos_y), 32'd0);
            chk("stall_step", 32'(bus.step_cnt), 32'd0);
            tick();
        end
        bus.move_ready = 1'b1;
        tick();
        chk("stall_hold_valid", 32'(bus.move_valid), 32'd0);
        chk("stall_hold_step", 32'(bus.step_cnt), 32'd1);
        chk("stall_hold_x", 32'(bus.pos_x), 32'd1);
        wait_finish("stall");
        bus.read_start = 1'b0;

        // Start level held through finish must not retrigger
        load_queue(1, {6'b0, 2'b11});
        arm_and_start();
        wait_finish("held");
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.q_deq || bus.move_valid || bus.read_path_finished) cnt++;
        end
        chk("held_no_restart", 32'(cnt), 32'd0);
        load_queue(1, {6'b0, 2'b01});
        bus.read_start = 1'b0;
        tick();
        bus.read_start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (bus.move_valid) seen = 1'b1;
        end
        chk("held_restart", 32'(seen), 32'd1);
        chk("held_restart_x", 32'(bus.pos_x), 32'd1);
        chk("held_restart_y", 32'(bus.pos_y), 32'd0);
        wait_finish("held_restart");
        bus.read_start = 1'b0;

        // Asynchronous reset during the hold of the second move
        load_queue(3, {2'b00, 2'b01, 2'b11, 2'b01});
        arm_and_start();
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 2; c++) begin
            tick();
            if (bus.move_valid) cnt++;
        end
        chk("rst_second_move", 32'(cnt), 32'd2);
        tick();
        tick();
        chk("rst_in_hold", 32'(bus.move_valid), 32'd0);
        chk("rst_pre_x", 32'(bus.pos_x), 32'd1);
        chk("rst_pre_y", 32'(bus.pos_y), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.read_path_finished || bus.q_deq || bus.move_valid) cnt++;
        end
        chk("rst_no_finish", 32'(cnt), 32'd0);
        bus.read_start = 1'b0;
        qend = qhead;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/path_player.md
PATH_PLAYER -- requirements
Module: path_player

Interface
REQ-001 SHALL have parameter COORD_W, default 4, coordinate width in bits (maze side 2^COORD_W).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles each accepted move is held before the next fetch; legal range 1..255.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port read_start  input  1  level request from the maze controller to replay the solved path.
REQ-006 SHALL have port q_empty  input  1  path queue empty flag.
REQ-007 SHALL have port q_data  input  2  queue head direction code: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1); valid the cycle after q_deq.
REQ-008 SHALL have port q_deq  output  1  one-cycle dequeue strobe to the path queue.
REQ-009 SHALL have port move_valid  output  1  move presented to the display sink.
REQ-010 SHALL have port move_ready  input  1  sink accepts the move.
REQ-011 SHALL have port move_dir  output  2  direction code of the presented move.
REQ-012 SHALL have port pos_x  output  COORD_W  x coordinate after the presented move.
REQ-013 SHALL have port pos_y  output  COORD_W  y coordinate after the presented move.
REQ-014 SHALL have port step_cnt  output  8  number of moves accepted in the current replay.
REQ-015 SHALL have port read_path_finished  output  1  one-cycle pulse when replay completes.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, LOAD, PRESENT, HOLD, FINISH.
REQ-017 IDLE: q_deq=0, move_valid=0; go to FETCH when read_start=1 and armed=1; on that transition clear pos_x, pos_y, step_cnt to 0.
REQ-018 armed SHALL be set in IDLE whenever read_start=0 and cleared on entry to FETCH from IDLE; a read_start held high across FINISH SHALL NOT restart replay.
REQ-019 FETCH: if q_empty=1 go to FINISH with q_deq=0; else assert q_deq for exactly this cycle and go to LOAD.
REQ-020 LOAD: register q_data into move_dir and update pos per REQ-007; go to PRESENT.
REQ-021 Coordinate arithmetic SHALL wrap modulo 2^COORD_W (0 minus 1 gives all-ones; all-ones plus 1 gives 0).
REQ-022 PRESENT: move_valid=1; move_dir, pos_x, pos_y SHALL stay stable until the cycle move_ready=1 is sampled; on that cycle increment step_cnt (saturate at 255), load hold counter with HOLD_CYCLES-1, go to HOLD.
REQ-023 HOLD: move_valid=0, outputs stable; decrement counter each cycle; when counter is 0 go to FETCH (total HOLD_CYCLES cycles in HOLD).
REQ-024 FINISH: read_path_finished=1 for exactly one cycle; go to IDLE.
REQ-025 read_start deassertion in any state other than IDLE SHALL be ignored; replay runs to FINISH.
REQ-026 q_deq SHALL never assert while q_empty=1 and never in two consecutive cycles.
REQ-027 move_ready while move_valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL force state IDLE, armed=0, q_deq=0, move_valid=0, move_dir=0, pos_x=0, pos_y=0, step_cnt=0, read_path_finished=0, hold counter=0, asynchronously, at any point including mid-replay.

Verification
REQ-029 Queue {01,01,11}, read_start=1, move_ready=1 constant, HOLD_CYCLES=4 -> moves (1,0),(2,0),(2,1); step_cnt=3; one read_path_finished pulse; 3 q_deq pulses.
REQ-030 Empty queue, read_start=1 -> FETCH then FINISH; read_path_finished pulse 2 cycles after read_start; no q_deq, no move_valid.
REQ-031 Queue {10}, start pos 0 -> pos_x=all-ones (15), pos_y=0 (wrap).
REQ-032 move_ready held 0 for 10 cycles in PRESENT -> move_valid and move data stable all 10 cycles; step_cnt unchanged until ready.
REQ-033 read_start held high after FINISH -> no second replay until read_start drops for one cycle and rises again.
REQ-034 rst pulse during HOLD of second move -> all outputs zero immediately; no read_path_finished pulse.
